// File: rtl/pulse_stretcher_pkg.sv
// Shared state encoding and the length-load helper for pulse_stretcher.
// Lengths are handled internally at up to LEN_MAX_W bits, so W must not exceed 32.
package pulse_stretcher_pkg;

  localparam int LEN_MAX_W = 32;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HIGH = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_HIGH = ST_HIGH,
    S_GAP  = ST_GAP
  } state_t;

  // Counter load value for a requested length: max(len,1)-1, so len==0 behaves as 1.
  function automatic logic [LEN_MAX_W-1:0] len_load(input logic [LEN_MAX_W-1:0] len);
    return (len == '0) ? '0 : len - LEN_MAX_W'(1);
  endfunction

endpackage

// File: rtl/pulse_cnt.sv
// W-bit loadable down-counter; load has priority over dec, and it saturates at zero.
module pulse_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         zero
);

  logic [W-1:0] cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (dec && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - W'(1);
    end
  end

  assign cnt  = cnt_reg;
  assign zero = (cnt_reg == '0);

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches a single-cycle trigger into a len-cycle pulse followed by GAP_CYC forced low cycles.
// Optional build macro PULSE_STRETCHER_RETRIGGER_EN: a trigger during the pulse reloads its length.
module pulse_stretcher
  import pulse_stretcher_pkg::*;
#(
  parameter int W       = 8,
  parameter int GAP_CYC = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         trig,
  input  logic [W-1:0] len,
  output logic         pulse_out,
  output logic         busy,
  output logic         done,
  output logic         dropped
);

  localparam logic [W-1:0] GAP_LOAD = (GAP_CYC > 0) ? W'(GAP_CYC - 1) : '0;

  state_t       state_reg;
  state_t       state_next;
  logic         cnt_load;
  logic [W-1:0] cnt_load_val;
  logic         cnt_dec;
  logic [W-1:0] cnt;
  logic         cnt_zero;
  logic [W-1:0] len_val;
  logic         done_next;
  logic         dropped_next;
  logic         pulse_reg;
  logic         busy_reg;
  logic         done_reg;
  logic         dropped_reg;

  assign len_val = W'(len_load(LEN_MAX_W'(len)));

  pulse_cnt #(
    .W(W)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;
    done_next    = 1'b0;
    dropped_next = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (trig) begin
          state_next   = S_HIGH;
          cnt_load     = 1'b1;
          cnt_load_val = len_val;
        end
      end
      S_HIGH: begin
`ifdef PULSE_STRETCHER_RETRIGGER_EN
        if (trig) begin
          // Reloading keeps the state in HIGH, so the pulse continues without a low cycle.
          cnt_load     = 1'b1;
          cnt_load_val = len_val;
        end else
`else
        dropped_next = trig;
`endif
        if (!cnt_zero) begin
          cnt_dec = 1'b1;
        end else begin
          done_next = 1'b1;
          if (GAP_CYC == 0) begin
            state_next = S_IDLE;
          end else begin
            state_next   = S_GAP;
            cnt_load     = 1'b1;
            cnt_load_val = GAP_LOAD;
          end
        end
      end
      S_GAP: begin
        dropped_next = trig;
        if (!cnt_zero) begin
          cnt_dec = 1'b1;
        end else begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Outputs decode the next state so they line up with the state register, glitch-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pulse_reg   <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      dropped_reg <= 1'b0;
    end else begin
      pulse_reg   <= (state_next == S_HIGH);
      busy_reg    <= (state_next != S_IDLE);
      done_reg    <= done_next;
      dropped_reg <= dropped_next;
    end
  end

  assign pulse_out = pulse_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;
  assign dropped   = dropped_reg;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Self-checking bench for pulse_stretcher: vector table, corner-case sequences, random vs. model.
module tb_pulse_stretcher;

  localparam int W   = 8;
  localparam int GAP = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         trig = 1'b0;
  logic [W-1:0] len = '0;
  logic         pulse_out, busy, done, dropped;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  // Model: absolute cycle numbers of the current pulse window and pending dropped strobe.
  int hi_start, hi_end, busy_end, drop_at;
  int first_hi, last_hi, done_c, drop_c, last_busy;

  typedef struct {
    logic       trig;
    logic [7:0] len;
    logic [3:0] exp;  // {pulse_out, busy, done, dropped}
  } vec_t;
  vec_t tbl [13];

  pulse_stretcher #(.W(W), .GAP_CYC(GAP)) dut (
    .clk       (clk),
    .rst       (rst),
    .trig      (trig),
    .len       (len),
    .pulse_out (pulse_out),
    .busy      (busy),
    .done      (done),
    .dropped   (dropped)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic void model_reset();
    hi_start = -100; hi_end = -100; busy_end = -100; drop_at = -100;
  endfunction

  function automatic void rec_reset();
    first_hi = -1; last_hi = -1; done_c = -1; drop_c = -1; last_busy = -1;
  endfunction

  function automatic void model_trig(input logic [7:0] l);
    int n;
    n = (l == 0) ? 1 : int'(l);
    if (cyc > busy_end) begin
      hi_start = cyc + 1;
      hi_end   = cyc + n;
      busy_end = hi_end + GAP;
    end else if (cyc >= hi_start && cyc <= hi_end) begin
`ifdef PULSE_STRETCHER_RETRIGGER_EN
      hi_end   = cyc + n;
      busy_end = hi_end + GAP;
`else
      drop_at = cyc + 1;
`endif
    end else begin
      drop_at = cyc + 1;
    end
  endfunction

  task automatic check_model();
    chk("pulse_out", pulse_out, (cyc >= hi_start && cyc <= hi_end) ? 1 : 0);
    chk("busy", busy, (cyc >= hi_start && cyc <= busy_end) ? 1 : 0);
    chk("done", done, (cyc == hi_end + 1) ? 1 : 0);
    chk("dropped", dropped, (cyc == drop_at) ? 1 : 0);
    if (pulse_out === 1'b1) begin
      if (first_hi < 0) first_hi = cyc;
      last_hi = cyc;
    end
    if (busy === 1'b1) last_busy = cyc;
    if (done === 1'b1) done_c = cyc;
    if (dropped === 1'b1) drop_c = cyc;
  endtask

  task automatic step(input logic t, input logic [7:0] l);
    trig = t;
    len  = l;
    if (t) model_trig(l);
    @(posedge clk);
    #1;
    cyc++;
    trig = 1'b0;
    check_model();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_pulse_out", pulse_out, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    model_reset();
    rec_reset();
    check_model();
  endtask

  task automatic idle_to(input int c);
    while (cyc < c) step(1'b0, 8'd0);
  endtask

  task automatic scenario(input string name, input int t2, input logic [7:0] l1,
                          input logic [7:0] l2, input int ncyc);
    do_reset();
    idle_to(10);
    step(1'b1, l1);
    while (cyc < ncyc) begin
      if (cyc == t2) step(1'b1, l2);
      else step(1'b0, 8'd0);
    end
    $display("scenario %s: high %0d..%0d done %0d dropped %0d busy_last %0d",
             name, first_hi, last_hi, done_c, drop_c, last_busy);
  endtask

  initial begin
    #300000;
    $display("FAIL timeout cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = '{1'b1, 8'd4, 4'b0000};
    tbl[1]  = '{1'b0, 8'd0, 4'b1100};
    tbl[2]  = '{1'b0, 8'd0, 4'b1100};
    tbl[3]  = '{1'b0, 8'd0, 4'b1100};
    tbl[4]  = '{1'b0, 8'd0, 4'b1100};
    tbl[5]  = '{1'b0, 8'd0, 4'b0110};
    tbl[6]  = '{1'b1, 8'd7, 4'b0100};
    tbl[7]  = '{1'b1, 8'd2, 4'b0001};
    tbl[8]  = '{1'b0, 8'd0, 4'b1100};
    tbl[9]  = '{1'b0, 8'd0, 4'b1100};
    tbl[10] = '{1'b0, 8'd0, 4'b0110};
    tbl[11] = '{1'b0, 8'd0, 4'b0100};
    tbl[12] = '{1'b0, 8'd0, 4'b0000};

    #2;
    do_reset();
    idle_to(10);
    for (int i = 0; i < 13; i++) begin
      chk("vec_outputs", {pulse_out, busy, done, dropped}, tbl[i].exp);
      step(tbl[i].trig, tbl[i].len);
    end
    $display("vector table: %0d rows applied", 13);

    scenario("len0", -1, 8'd0, 8'd0, 20);
    chk("len0_first", first_hi, 11);
    chk("len0_last", last_hi, 11);
    chk("len0_done", done_c, 12);

    scenario("len255", -1, 8'd255, 8'd0, 275);
    chk("len255_first", first_hi, 11);
    chk("len255_last", last_hi, 265);
    chk("len255_done", done_c, 266);

    scenario("gap_trig", 15, 8'd4, 8'd4, 25);
    chk("gap_last_hi", last_hi, 14);
    chk("gap_dropped", drop_c, 16);
    chk("gap_busy_last", last_busy, 16);

    scenario("mid_high_trig", 12, 8'd4, 8'd3, 25);
`ifdef PULSE_STRETCHER_RETRIGGER_EN
    chk("mid_last_hi", last_hi, 15);
    chk("mid_done", done_c, 16);
    chk("mid_dropped", drop_c, -1);
`else
    chk("mid_last_hi", last_hi, 14);
    chk("mid_done", done_c, 15);
    chk("mid_dropped", drop_c, 13);
`endif

    scenario("last_high_trig", 14, 8'd4, 8'd2, 25);
`ifdef PULSE_STRETCHER_RETRIGGER_EN
    chk("last_last_hi", last_hi, 16);
    chk("last_done", done_c, 17);
    chk("last_dropped", drop_c, -1);
`else
    chk("last_last_hi", last_hi, 14);
    chk("last_done", done_c, 15);
    chk("last_dropped", drop_c, 15);
`endif

    // Asynchronous reset in the middle of a pulse.
    do_reset();
    idle_to(10);
    step(1'b1, 8'd10);
    idle_to(13);
    #3;
    rst = 1'b1;
    #1;
    chk("async_pulse_out", pulse_out, 0);
    chk("async_busy", busy, 0);
    chk("async_done", done, 0);
    chk("async_dropped", dropped, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    model_reset();
    rec_reset();
    check_model();
    step(1'b1, 8'd3);
    chk("post_rst_latency", pulse_out, 1);
    idle_to(8);
    chk("post_rst_done", done_c, 4);
    $display("scenario async_rst: high %0d..%0d done %0d", first_hi, last_hi, done_c);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic       t;
      logic [7:0] l;
      t = ($urandom_range(0, 2) == 0);
      l = ($urandom_range(0, 19) == 0) ? 8'd255 : 8'($urandom_range(0, 9));
      step(t, l);
    end
    $display("random: %0d cycles", 3000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
